// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: owns the PC, issues word reads to a synchronous ROM,
// and buffers returned instructions in a small FIFO towards decode.
module if_fetch_queue #(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned DEPTH   = 4,
  parameter logic [31:0] RST_VEC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_flag,
  input  logic                       int_flag,
  input  logic [31:0]                int_addr,
  input  logic                       redir_flag,
  input  logic [31:0]                redir_addr,
  output logic [ADDR_W-1:0]          rom_addr,
  output logic                       rom_rd,
  input  logic [31:0]                rom_data,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst,
  output logic [31:0]                inst_pc,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [31:0]      fetch_pc;
  logic [31:0]      rd_pc;
  logic [31:0]      ret_pc;
  logic             ret_live;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [31:0]      mem_inst [DEPTH];
  logic [31:0]      mem_pc   [DEPTH];

  logic             flush;
  logic [31:0]      target;
  logic             push;
  logic             pop;
  logic [OCC_W-1:0] occ;
  logic             issue;

  // Issue decision: slots claimed after this edge must stay within DEPTH
  always_comb begin
    flush  = int_flag || redir_flag;
    target = int_flag ? int_addr : redir_addr;
    push   = ret_live;
    pop    = inst_valid && inst_ready;
    occ    = OCC_W'(q_count) + OCC_W'(rom_rd) + OCC_W'(push) - OCC_W'(pop);
    issue  = !flush && (occ < OCC_W'(DEPTH));
  end

  assign inst_valid = (q_count != '0);
  assign inst       = mem_inst[head];
  assign inst_pc    = mem_pc[head];

  // rom_rd/rd_pc track the read the ROM is sampling; ret_* tracks the data on rom_data
  always_ff @(posedge clk) begin
    if (!rst_flag) begin
      fetch_pc <= RST_VEC;
      rom_rd   <= 1'b0;
      rom_addr <= '0;
      rd_pc    <= '0;
      ret_pc   <= '0;
      ret_live <= 1'b0;
      head     <= '0;
      tail     <= '0;
      q_count  <= '0;
    end else begin
      ret_live <= rom_rd && !flush;
      ret_pc   <= rd_pc;
      rom_rd   <= issue;
      if (flush) begin
        fetch_pc <= target & ~32'h3;
        head     <= '0;
        tail     <= '0;
        q_count  <= '0;
      end else begin
        if (issue) begin
          rom_addr <= fetch_pc[ADDR_W+1:2];
          rd_pc    <= fetch_pc;
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push) tail <= tail + PTR_W'(1);
        if (pop)  head <= head + PTR_W'(1);
        q_count <= q_count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Queue payload storage; needs no reset since q_count gates visibility
  always_ff @(posedge clk) begin
    if (rst_flag && !flush && push) begin
      mem_inst[tail] <= rom_data;
      mem_pc[tail]   <= ret_pc;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed scenarios plus a randomized
// phase checked against an expected instruction-stream model.
module tb_if_fetch_queue;

  localparam int unsigned AW = 13;
  localparam int unsigned D  = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_flag = 1'b0;
  logic        int_flag = 1'b0;
  logic [31:0] int_addr = '0;
  logic        redir_flag = 1'b0;
  logic [31:0] redir_addr = '0;
  logic [AW-1:0] rom_addr;
  logic        rom_rd;
  logic [31:0] rom_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [2:0]  q_count;

  logic [3:0]  s_rom_addr;
  logic        s_rom_rd;
  logic [31:0] s_rom_data = '0;
  logic        s_inst_valid;
  logic [31:0] s_inst;
  logic [31:0] s_inst_pc;
  logic [2:0]  s_q_count;

  if_fetch_queue #(.ADDR_W(AW), .DEPTH(D), .RST_VEC(32'h100)) u_dut (
    .clk(clk), .rst_flag(rst_flag), .int_flag(int_flag), .int_addr(int_addr),
    .redir_flag(redir_flag), .redir_addr(redir_addr), .rom_addr(rom_addr),
    .rom_rd(rom_rd), .rom_data(rom_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .q_count(q_count)
  );

  if_fetch_queue #(.ADDR_W(4), .DEPTH(D), .RST_VEC(32'h3C)) u_small (
    .clk(clk), .rst_flag(rst_flag), .int_flag(1'b0), .int_addr(32'h0),
    .redir_flag(1'b0), .redir_addr(32'h0), .rom_addr(s_rom_addr),
    .rom_rd(s_rom_rd), .rom_data(s_rom_data), .inst_valid(s_inst_valid),
    .inst_ready(1'b1), .inst(s_inst), .inst_pc(s_inst_pc), .q_count(s_q_count)
  );

  // Synchronous ROMs: word k holds 0xA000_0000 + k
  always @(posedge clk) begin
    if (rom_rd)   rom_data   <= 32'hA000_0000 + 32'(rom_addr);
    if (s_rom_rd) s_rom_data <= 32'hA000_0000 + 32'(s_rom_addr);
  end

  logic watch  = 1'b0;
  logic saw300 = 1'b0;
  always @(posedge clk)
    if (watch && rom_rd && rom_addr == 13'h0C0) saw300 <= 1'b1;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_pc;
  int accepted = 0;

  function automatic logic [31:0] word_of(input logic [31:0] pc, input int unsigned aw);
    return 32'hA000_0000 + ((pc >> 2) & ((32'd1 << aw) - 32'd1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consume n instructions with ready held high, each must continue the expected stream
  task automatic drain_check(input int n);
    inst_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (!inst_valid && w < 20) begin
        tick();
        w++;
      end
      chk("head_valid", 32'(inst_valid), 32'd1);
      chk("head_pc", inst_pc, exp_pc);
      chk("head_inst", inst, word_of(exp_pc, AW));
      exp_pc = exp_pc + 32'd4;
      tick();
    end
  endtask

  task automatic wait_count(input int n);
    int w = 0;
    while (32'(q_count) != n && w < 40) begin
      tick();
      w++;
    end
    chk("wait_q_count", 32'(q_count), n);
  endtask

  initial begin
    logic flush_prev;
    // Reset state
    repeat (3) tick();
    chk("rst_q_count", 32'(q_count), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_rom_rd", 32'(rom_rd), 32'd0);

    // Startup latency and stream; small instance checks ROM address wrap
    rst_flag = 1'b1;
    tick();
    chk("e0_valid", 32'(inst_valid), 32'd0);
    chk("s_e0_rd", 32'(s_rom_rd), 32'd1);
    chk("s_e0_addr", 32'(s_rom_addr), 32'd15);
    tick();
    chk("e1_valid", 32'(inst_valid), 32'd0);
    chk("s_e1_addr", 32'(s_rom_addr), 32'd0);
    tick();
    chk("e2_valid", 32'(inst_valid), 32'd1);
    chk("e2_pc", inst_pc, 32'h100);
    chk("e2_inst", inst, 32'hA000_0040);
    chk("s_e2_addr", 32'(s_rom_addr), 32'd1);
    chk("s_e2_pc", s_inst_pc, 32'h3C);
    chk("s_e2_inst", s_inst, 32'hA000_000F);
    tick();
    chk("e3_pc", inst_pc, 32'h104);
    chk("e3_inst", inst, 32'hA000_0041);
    chk("e3_q_count", 32'(q_count), 32'd1);
    chk("s_e3_pc", s_inst_pc, 32'h40);
    chk("s_e3_inst", s_inst, 32'hA000_0000);
    tick();
    chk("e4_pc", inst_pc, 32'h108);
    chk("s_e4_pc", s_inst_pc, 32'h44);
    chk("s_e4_inst", s_inst, 32'hA000_0001);

    // Back-pressure: saturate, then drain in order
    inst_ready = 1'b0;
    exp_pc = 32'h108;
    repeat (10) tick();
    chk("bp_q_count", 32'(q_count), 32'd4);
    chk("bp_rom_rd", 32'(rom_rd), 32'd0);
    drain_check(8);

    // Redirect with 3 queued entries and data returning
    inst_ready = 1'b0;
    wait_count(3);
    redir_flag = 1'b1;
    redir_addr = 32'h203;
    tick();
    redir_flag = 1'b0;
    chk("redir_q_count", 32'(q_count), 32'd0);
    chk("redir_valid", 32'(inst_valid), 32'd0);
    exp_pc = 32'h200;
    drain_check(4);

    // Interrupt beats redirect in the same cycle
    watch = 1'b1;
    int_flag = 1'b1;
    int_addr = 32'h40;
    redir_flag = 1'b1;
    redir_addr = 32'h300;
    tick();
    int_flag = 1'b0;
    redir_flag = 1'b0;
    chk("prio_q_count", 32'(q_count), 32'd0);
    exp_pc = 32'h40;
    drain_check(6);
    watch = 1'b0;
    chk("prio_no_300", 32'(saw300), 32'd0);

    // PC wraps modulo 2^32
    redir_flag = 1'b1;
    redir_addr = 32'hFFFF_FFF8;
    tick();
    redir_flag = 1'b0;
    exp_pc = 32'hFFFF_FFF8;
    drain_check(4);

    // Reset mid-stream with a full queue
    inst_ready = 1'b0;
    wait_count(4);
    rst_flag = 1'b0;
    tick();
    chk("mrst_q_count", 32'(q_count), 32'd0);
    chk("mrst_valid", 32'(inst_valid), 32'd0);
    chk("mrst_rom_rd", 32'(rom_rd), 32'd0);
    rst_flag = 1'b1;
    exp_pc = 32'h100;
    drain_check(4);

    // Randomized back-pressure and redirects against the expected stream
    flush_prev = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      int r;
      if (flush_prev) chk("rnd_flush_q", 32'(q_count), 32'd0);
      chk("rnd_q_le_depth", 32'(q_count <= 3'(D)), 32'd1);
      inst_ready = ($urandom % 4) != 0;
      if (inst_valid && inst_ready) begin
        chk("rnd_pc", inst_pc, exp_pc);
        chk("rnd_inst", inst, word_of(exp_pc, AW));
        exp_pc = exp_pc + 32'd4;
        accepted++;
      end
      r = int'($urandom % 64);
      int_flag   = (r == 0);
      redir_flag = (r < 3);
      int_addr   = $urandom;
      redir_addr = $urandom;
      flush_prev = int_flag || redir_flag;
      if (int_flag) exp_pc = int_addr & ~32'h3;
      else if (redir_flag) exp_pc = redir_addr & ~32'h3;
      tick();
      int_flag = 1'b0;
      redir_flag = 1'b0;
    end
    chk("rnd_progress", 32'(accepted > 500), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised next-generation instruction fetch stage: owns the PC, issues word reads to a synchronous instruction ROM, and buffers returned instructions in a FIFO.
- Decouples fetch from decode through a valid/ready handshake.
- Supports redirect (jump/branch resolved downstream) and interrupt with flush of queued and in-flight instructions.
- Sits between the instruction ROM array and the decode/execute stage.

Parameters:
- ADDR_W, 13: ROM word-address width; ROM address = pc[ADDR_W+1:2].
- DEPTH, 4: instruction queue entries; power of two, minimum 2.
- RST_VEC, 32'h0000_0000: PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_flag  in  1  synchronous reset, active LOW.
- int_flag  in  1  interrupt request, active HIGH, single-cycle pulse.
- int_addr  in  32  interrupt target address.
- redir_flag  in  1  redirect request (taken branch/jal/jalr), active HIGH.
- redir_addr  in  32  redirect target address.
- rom_addr  out  ADDR_W  ROM word address.
- rom_rd  out  1  ROM read strobe; data returns exactly one cycle later.
- rom_data  in  32  ROM read data, valid the cycle after rom_rd.
- inst_valid  out  1  queue head holds a valid instruction.
- inst_ready  in  1  consumer accepts the head this cycle.
- inst  out  32  head instruction.
- inst_pc  out  32  PC of the head instruction.
- q_count  out  $clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (rst_flag=0 at a rising edge):
  - fetch_pc=RST_VEC; queue empty (q_count=0, inst_valid=0).
  - In-flight tag cleared; rom_rd=0 during the reset cycle.
  - inst and inst_pc are don't-care while inst_valid=0.
- Issue:
  - rom_rd=1 when (q_count + inflight + push_this_cycle - pop_this_cycle) < DEPTH, and no redirect or interrupt is active this cycle.
  - On issue: rom_addr=fetch_pc[ADDR_W+1:2]; an in-flight record {pc=fetch_pc, live=1} is captured; fetch_pc += 4.
  - At most one read is in flight; sustained throughput is 1 instruction/cycle when the queue is not full.
- Return:
  - The cycle after an issue, if the in-flight record is live, {rom_data, pc} is pushed at the queue tail.
  - The free-slot check guarantees the push never overflows.
- Pop:
  - inst_valid && inst_ready removes the head.
  - Push and pop in the same cycle leave q_count unchanged.
  - Pop on an empty queue is ignored.
- Redirect/interrupt, priority reset > int_flag > redir_flag:
  - Queue is flushed (q_count=0 next cycle).
  - The in-flight record is marked dead, so its returning rom_data is dropped.
  - fetch_pc = target with bits[1:0] forced to 0.
  - No issue occurs in the request cycle. The first issue to the new target is the next cycle, so the first new instruction reaches the queue head no earlier than 2 cycles after the request.
  - A pop in the request cycle is still honoured for the current head.
- PC arithmetic:
  - fetch_pc wraps modulo 2^32.
  - ROM address wraps modulo 2^ADDR_W words.
- Outputs are registered except inst_valid, inst and inst_pc, which are driven directly from the queue head registers.
- Full queue: rom_rd=0 and fetch_pc holds.
- Back-pressure (inst_ready=0) never loses or duplicates an instruction.

Test Plan:
- Reset with RST_VEC=0x100, ROM word k = 0xA000_0000+k, inst_ready=1 -> first inst_valid 2 cycles after reset release; stream 0xA000_0040 (pc 0x100), 0xA000_0041 (pc 0x104), ... at 1/cycle.
- Hold inst_ready=0 for 10 cycles, DEPTH=4 -> q_count saturates at 4, rom_rd deasserts; on release, queue drains with pcs in order and no gaps or duplicates.
- redir_flag with redir_addr=0x203 while queue holds 3 entries and a read is in flight -> q_count=0 next cycle, stale data dropped, next head pc=0x200 with inst=ROM word 0x80.
- int_flag (int_addr=0x40) and redir_flag (0x300) in the same cycle -> fetch resumes at 0x40; 0x300 is never fetched.
- rst_flag=0 asserted mid-stream with a full queue -> next cycle q_count=0, inst_valid=0, fetch restarts at RST_VEC.
- ADDR_W=4, fetch_pc=0x3C, continuous fetch -> rom_addr sequence 15, 0, 1; inst_pc sequence 0x3C, 0x40, 0x44.
